// File: rtl/hp_manager_if.sv
// hp_manager_if: game-control inputs and HP/result outputs of the HP manager
interface hp_manager_if #(
    parameter int HP_W = 4
);
    logic            START;
    logic [1:0]      WL_IN;
    logic [HP_W-1:0] MY_HP;
    logic [HP_W-1:0] EN_HP;
    logic            HIT;
    logic [1:0]      HIT_WHO;
    logic [7:0]      ROUND;
    logic            GAME_OVER;
    logic [1:0]      RESULT;

    modport master (
        output START, WL_IN,
        input  MY_HP, EN_HP, HIT, HIT_WHO, ROUND, GAME_OVER, RESULT
    );

    modport slave (
        input  START, WL_IN,
        output MY_HP, EN_HP, HIT, HIT_WHO, ROUND, GAME_OVER, RESULT
    );
endinterface

// File: rtl/hp_manager.sv
// hp_manager: two-player HP bookkeeping, applies each round verdict exactly once
module hp_manager #(
    parameter int HP_W    = 4,
    parameter int HP_INIT = 5,
    parameter int DAMAGE  = 1
) (
    input logic         CLK,
    input logic         RST,
    hp_manager_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARM, PLAY, LOCK, OVER} state_t;

    localparam logic [HP_W-1:0] INIT = HP_W'(HP_INIT);
    localparam logic [HP_W-1:0] DMG  = HP_W'(DAMAGE);

    state_t          state, next_state;
    logic            apply, load, done;
    logic [HP_W-1:0] my_sub, en_sub, my_nxt, en_nxt;

    // saturating HP arithmetic and next state, using post-update HP for the OVER decision
    always_comb begin
        apply  = state == PLAY && bus.WL_IN != 2'b00;
        load   = bus.START && (state == IDLE || state == OVER);
        my_sub = (int'(bus.MY_HP) > DAMAGE) ? bus.MY_HP - DMG : '0;
        en_sub = (int'(bus.EN_HP) > DAMAGE) ? bus.EN_HP - DMG : '0;
        my_nxt = (apply && bus.WL_IN[1]) ? my_sub : bus.MY_HP;
        en_nxt = (apply && bus.WL_IN[0]) ? en_sub : bus.EN_HP;
        done   = my_nxt == '0 || en_nxt == '0;
        next_state = state;
        case (state)
            IDLE:    next_state = bus.START ? ARM : IDLE;
            ARM:     next_state = bus.WL_IN == 2'b00 ? PLAY : ARM;
            PLAY:    next_state = apply ? (done ? OVER : LOCK) : PLAY;
            LOCK:    next_state = bus.WL_IN == 2'b00 ? PLAY : LOCK;
            OVER:    next_state = bus.START ? ARM : OVER;
            default: next_state = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    // registered outputs: HP, round count, verdict pulse and game result
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus.MY_HP     <= INIT;
            bus.EN_HP     <= INIT;
            bus.HIT       <= 1'b0;
            bus.HIT_WHO   <= 2'b00;
            bus.ROUND     <= 8'd0;
            bus.GAME_OVER <= 1'b0;
            bus.RESULT    <= 2'b00;
        end else begin
            bus.HIT       <= apply;
            bus.GAME_OVER <= next_state == OVER;
            if (load) begin
                bus.MY_HP  <= INIT;
                bus.EN_HP  <= INIT;
                bus.ROUND  <= 8'd0;
                bus.RESULT <= 2'b00;
            end else if (apply) begin
                bus.MY_HP   <= my_nxt;
                bus.EN_HP   <= en_nxt;
                bus.HIT_WHO <= bus.WL_IN;
                bus.ROUND   <= bus.ROUND == 8'hFF ? bus.ROUND : bus.ROUND + 8'd1;
                if (done) bus.RESULT <= {my_nxt == '0, en_nxt == '0};
            end
        end
    end
endmodule

// File: tb/tb_hp_manager.sv
// tb_hp_manager: directed vector table plus hand sequences for HP manager corner cases
module tb_hp_manager;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    always #5 CLK = ~CLK;

    hp_manager_if #(.HP_W(4)) b1 ();
    hp_manager_if #(.HP_W(4)) b2 ();
    hp_manager_if #(.HP_W(4)) b3 ();

    hp_manager #(.HP_W(4), .HP_INIT(5), .DAMAGE(1)) d1 (.CLK(CLK), .RST(RST), .bus(b1.slave));
    hp_manager #(.HP_W(4), .HP_INIT(1), .DAMAGE(1)) d2 (.CLK(CLK), .RST(RST), .bus(b2.slave));
    hp_manager #(.HP_W(4), .HP_INIT(5), .DAMAGE(3)) d3 (.CLK(CLK), .RST(RST), .bus(b3.slave));

    typedef struct {
        logic       start;
        logic [1:0] wl;
        logic [3:0] my;
        logic [3:0] en;
        logic       hit;
        logic [1:0] who;
        logic [7:0] round;
        logic       over;
        logic [1:0] res;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic [1:0] w, input logic [3:0] m, input logic [3:0] e,
                                input logic h, input logic [1:0] wh, input logic [7:0] r, input logic o,
                                input logic [1:0] rs);
        vec_t v;
        v.start = s; v.wl = w; v.my = m; v.en = e; v.hit = h; v.who = wh; v.round = r; v.over = o; v.res = rs;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk1(input string n, input vec_t v);
        chk({n, ".my"},     32'(b1.MY_HP),     32'(v.my));
        chk({n, ".en"},     32'(b1.EN_HP),     32'(v.en));
        chk({n, ".hit"},    32'(b1.HIT),       32'(v.hit));
        chk({n, ".who"},    32'(b1.HIT_WHO),   32'(v.who));
        chk({n, ".round"},  32'(b1.ROUND),     32'(v.round));
        chk({n, ".over"},   32'(b1.GAME_OVER), 32'(v.over));
        chk({n, ".result"}, 32'(b1.RESULT),    32'(v.res));
    endtask

    initial begin
        b1.START = 0; b1.WL_IN = 0;
        b2.START = 0; b2.WL_IN = 0;
        b3.START = 0; b3.WL_IN = 0;
        #12;
        chk1("reset", mk(0, 0, 5, 5, 0, 0, 0, 0, 0));
        @(negedge CLK);
        RST = 1'b1;
        b1.WL_IN = 2'b01;
        tick();
        tick();
        chk1("idle_no_start", mk(0, 0, 5, 5, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 5, 5, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 5, 5, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++) begin
            logic [3:0] e;
            logic       o;
            e = 4'(4 - k);
            o = k == 4;
            vecs.push_back(mk(0, 1, 5, e, 1, 1, 8'(k + 1), o, {1'b0, o}));
            for (int j = 0; j < 2; j++) vecs.push_back(mk(0, 1, 5, e, 0, 1, 8'(k + 1), o, {1'b0, o}));
            for (int j = 0; j < 2; j++) vecs.push_back(mk(0, 0, 5, e, 0, 1, 8'(k + 1), o, {1'b0, o}));
        end
        vecs.push_back(mk(1, 0, 5, 5, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 5, 5, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 5, 5, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 2, 4, 5, 1, 2, 1, 0, 0));
        for (int j = 0; j < 19; j++) vecs.push_back(mk(0, 2, 4, 5, 0, 2, 1, 0, 0));
        vecs.push_back(mk(0, 0, 4, 5, 0, 2, 1, 0, 0));
        foreach (vecs[i]) begin
            b1.START = vecs[i].start;
            b1.WL_IN = vecs[i].wl;
            tick();
            chk1($sformatf("vec%0d", i), vecs[i]);
        end

        b2.START = 1; tick();
        chk("draw.arm_my", 32'(b2.MY_HP), 1);
        b2.START = 0; tick();
        b2.WL_IN = 2'b11; tick();
        chk("draw.hit", 32'(b2.HIT), 1);
        chk("draw.my", 32'(b2.MY_HP), 0);
        chk("draw.en", 32'(b2.EN_HP), 0);
        chk("draw.who", 32'(b2.HIT_WHO), 3);
        b2.WL_IN = 2'b00; tick();
        chk("draw.over", 32'(b2.GAME_OVER), 1);
        chk("draw.result", 32'(b2.RESULT), 3);
        chk("draw.hit_off", 32'(b2.HIT), 0);
        b2.WL_IN = 2'b01; tick();
        chk("draw.over_ignore", 32'({b2.HIT, b2.MY_HP, b2.EN_HP, b2.ROUND}), 32'({1'b0, 4'd0, 4'd0, 8'd1}));

        b3.WL_IN = 2'b01; b3.START = 1; tick();
        chk("stale.start_hit", 32'(b3.HIT), 0);
        b3.START = 0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("stale.held", 32'({b3.HIT, b3.EN_HP}), 32'({1'b0, 4'd5}));
        end
        b3.WL_IN = 2'b00; tick();
        chk("stale.release", 32'(b3.HIT), 0);
        b3.WL_IN = 2'b10; tick();
        chk("sat.hit1", 32'(b3.HIT), 1);
        chk("sat.my1", 32'(b3.MY_HP), 2);
        b3.WL_IN = 2'b00; tick();
        b3.WL_IN = 2'b10; tick();
        chk("sat.my2", 32'(b3.MY_HP), 0);
        chk("sat.en", 32'(b3.EN_HP), 5);
        chk("sat.result", 32'(b3.RESULT), 2);
        chk("sat.over", 32'(b3.GAME_OVER), 1);
        b3.WL_IN = 2'b00;

        b1.WL_IN = 2'b01; tick();
        chk1("pre_rst_hit", mk(0, 1, 4, 4, 1, 1, 2, 0, 0));
        tick();
        #3;
        RST = 1'b0;
        #1;
        chk1("async_rst", mk(0, 0, 5, 5, 0, 0, 0, 0, 0));
        #2;
        RST = 1'b1;
        b1.WL_IN = 2'b00; tick();
        b1.WL_IN = 2'b01;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk1("post_rst_idle", mk(0, 0, 5, 5, 0, 0, 0, 0, 0));
        end
        b1.START = 1; b1.WL_IN = 2'b00; tick();
        b1.START = 0; tick();
        b1.WL_IN = 2'b01; tick();
        chk1("post_rst_game", mk(0, 0, 5, 4, 1, 1, 1, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/hp_manager.md
HP_MANAGER -- requirements
Module: hp_manager

Parameters
REQ-001 The block SHALL have parameter HP_W, default 4, giving the HP counter width in bits.
REQ-002 The block SHALL have parameter HP_INIT, default 5, giving the starting HP of each player (1..2^HP_W-1).
REQ-003 The block SHALL have parameter DAMAGE, default 1, giving the HP removed per lost round (>=1).

Interface
REQ-004 The block SHALL have port CLK, input, width 1: the single clock, rising-edge.
REQ-005 The block SHALL have port RST, input, width 1: asynchronous reset, active-low.
REQ-006 The block SHALL have port START, input, width 1: level; begins or restarts a game (level sampled on the rising CLK edge).
REQ-007 The block SHALL have port WL_IN, input, width 2: round verdict from the win/lose judge; 00 none, 01 self wins, 10 enemy wins, 11 draw.
REQ-008 The block SHALL have port MY_HP, output, width HP_W: own HP, registered.
REQ-009 The block SHALL have port EN_HP, output, width HP_W: enemy HP, registered.
REQ-010 The block SHALL have port HIT, output, width 1: one-cycle pulse when a verdict is applied.
REQ-011 The block SHALL have port HIT_WHO, output, width 2: verdict applied with the last HIT (01/10/11); holds until the next HIT.
REQ-012 The block SHALL have port ROUND, output, width 8: count of applied verdicts this game.
REQ-013 The block SHALL have port GAME_OVER, output, width 1: high while in OVER.
REQ-014 The block SHALL have port RESULT, output, width 2: 00 undecided, 01 self wins game, 10 enemy wins game, 11 draw game.

Function
REQ-015 The block SHALL implement exactly five states: IDLE, ARM, PLAY, LOCK, OVER.
REQ-016 IDLE: on START=1 the block SHALL load MY_HP=EN_HP=HP_INIT, clear ROUND, set RESULT=00, and go to ARM.
REQ-017 ARM: the block SHALL stay in ARM while WL_IN!=00 and SHALL move to PLAY on the first cycle WL_IN=00, so that a stale verdict is never applied.
REQ-018 PLAY, WL_IN=01: the block SHALL set EN_HP <= EN_HP-DAMAGE.
REQ-019 PLAY, WL_IN=10: the block SHALL set MY_HP <= MY_HP-DAMAGE.
REQ-020 PLAY, WL_IN=11: the block SHALL decrement both HPs by DAMAGE.
REQ-021 In all three PLAY cases (REQ-018..020) the block SHALL also, on the same edge, assert HIT for one cycle, latch HIT_WHO=WL_IN, and increment ROUND (saturating at 255).
REQ-022 Every subtraction SHALL saturate at 0; HP SHALL never wrap.
REQ-023 After applying a verdict, the block SHALL go to OVER if either new HP is 0, else to LOCK; the next state SHALL be evaluated from the post-update HP values in the same cycle.
REQ-024 On entry to OVER the block SHALL set RESULT=11 if both HPs are 0, 01 if only EN_HP=0, and 10 if only MY_HP=0.
REQ-025 LOCK: the block SHALL ignore WL_IN while it is nonzero, and return to PLAY on the first cycle WL_IN=00, so that one verdict is applied once regardless of how many cycles it is held.
REQ-026 PLAY with WL_IN=00 SHALL cause no change.
REQ-027 START in ARM, PLAY, or LOCK SHALL be ignored.
REQ-028 OVER: HP, RESULT, and ROUND SHALL hold and WL_IN SHALL be ignored; START=1 SHALL re-run the IDLE load (REQ-016) and go to ARM in one cycle.
REQ-029 HIT SHALL be the only pulse output; all outputs SHALL be registered (no combinational path from inputs to outputs).

Reset
REQ-030 RST=0 SHALL asynchronously force state IDLE, MY_HP=EN_HP=HP_INIT, HIT=0, HIT_WHO=00, ROUND=0, GAME_OVER=0, RESULT=00.
REQ-031 Reset asserted mid-game (any state) SHALL abort the game with no further HP update.
REQ-032 After RST returns high, the block SHALL leave IDLE only on START.

Verification
REQ-033 Normal game: reset, START pulse, then 5x (WL_IN=01 for 3 cycles, 00 for 2 cycles) -> EN_HP steps 5,4,3,2,1,0; MY_HP=5; 5 HIT pulses; ROUND=5; RESULT=01; GAME_OVER=1.
REQ-034 Held verdict: in PLAY, hold WL_IN=10 for 20 cycles -> exactly one HIT; MY_HP=4; HIT_WHO=10.
REQ-035 Draw to zero: HP_INIT=1, START, WL_IN=11 -> both HPs 0; RESULT=11; GAME_OVER=1 on the cycle after HIT.
REQ-036 Stale verdict and saturation: WL_IN=01 held across START -> no HIT until WL_IN=00 then 01; with DAMAGE=3, HP_INIT=5, two enemy wins -> MY_HP 5->2->0 (no wrap); RESULT=10.
REQ-037 Restart and ignored START: START during PLAY -> no change; START in OVER -> HPs reload to 5, ROUND=0, RESULT=00 next cycle.
REQ-038 Async reset: RST=0 between clock edges mid-LOCK -> outputs take reset values immediately; START is then required before any HIT.
